// File: rtl/mini_cpu_param_if.sv
// Issue/result bundle for mini_cpu_param: instruction fields in, status and display result out.
// Handshake: a rising edge on enviar requests one instruction; while busy is high further edges are dropped; done pulses for exactly one cycle as busy falls and valor_final/overflow/mostrar hold until the next done.
interface mini_cpu_param_if #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4,
    parameter int IMM_W  = 6
);
    logic              enviar;
    logic [2:0]        opcode;
    logic [REG_AW-1:0] src1;
    logic [REG_AW-1:0] src2;
    logic [REG_AW-1:0] dest;
    logic              sinal_imm;
    logic [IMM_W-1:0]  imm;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] valor_final;
    logic              mostrar;
    logic              overflow;
    logic [2:0]        state_dbg;

    modport master (
        output enviar, opcode, src1, src2, dest, sinal_imm, imm,
        input  busy, done, valor_final, mostrar, overflow, state_dbg
    );

    modport slave (
        input  enviar, opcode, src1, src2, dest, sinal_imm, imm,
        output busy, done, valor_final, mostrar, overflow, state_dbg
    );
endinterface

// File: rtl/mini_cpu_param.sv
// Multi-cycle parametrised mini CPU: synchronised issue button, READ/EXEC/(MULT)/WB sequencer,
// NUM_REGS x DATA_W register file and a fixed-latency shift-add multiplier.
module mini_cpu_param #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4,
    parameter int IMM_W  = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    mini_cpu_param_if.slave  bus
);
    localparam int NUM_REGS = 2 ** REG_AW;
    localparam int CNT_W    = $clog2(DATA_W);
    localparam int MSB      = DATA_W - 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    localparam logic [2:0] OP_LOAD    = 3'd0;
    localparam logic [2:0] OP_ADD     = 3'd1;
    localparam logic [2:0] OP_ADDI    = 3'd2;
    localparam logic [2:0] OP_SUB     = 3'd3;
    localparam logic [2:0] OP_SUBI    = 3'd4;
    localparam logic [2:0] OP_MUL     = 3'd5;
    localparam logic [2:0] OP_CLEAR   = 3'd6;
    localparam logic [2:0] OP_DISPLAY = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_EXEC = 3'd2,
        S_MULT = 3'd3,
        S_WB   = 3'd4
    } state_t;

    state_t              state_q;
    logic                sync1_q, sync2_q, prev_q;
    logic [2:0]          op_q;
    logic [REG_AW-1:0]   src1_q, src2_q, dest_q;
    logic [DATA_W-1:0]   imm_q;
    logic [DATA_W-1:0]   op_a_q, op_b_q;
    logic [DATA_W-1:0]   result_q;
    logic                ovf_q;
    logic [2*DATA_W-1:0] acc_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [DATA_W-1:0]   valor_final_q;
    logic                overflow_q, mostrar_q, done_q;
    logic [DATA_W-1:0]   rf_q [NUM_REGS];

    logic                start;
    logic [DATA_W-1:0]   imm_zext, imm_ext;
    logic [DATA_W-1:0]   rhs, add_r, sub_r, alu_res;
    logic                alu_ovf;
    logic [2*DATA_W-1:0] partial, acc_d;

    // Only the synchronised level is edge-detected, so a held button issues once.
    assign start = sync2_q & ~prev_q;

    always_comb begin
        imm_zext = {{(DATA_W-IMM_W){1'b0}}, bus.imm};
        imm_ext  = bus.sinal_imm ? (DATA_W'(0) - imm_zext) : imm_zext;
    end

    always_comb begin
        rhs     = ((op_q == OP_ADDI) || (op_q == OP_SUBI)) ? imm_q : op_b_q;
        add_r   = op_a_q + rhs;
        sub_r   = op_a_q - rhs;
        alu_res = '0;
        alu_ovf = 1'b0;
        case (op_q)
            OP_LOAD:    alu_res = imm_q;
            OP_ADD, OP_ADDI: begin
                alu_res = add_r;
                alu_ovf = (op_a_q[MSB] == rhs[MSB]) && (add_r[MSB] != op_a_q[MSB]);
            end
            OP_SUB, OP_SUBI: begin
                alu_res = sub_r;
                alu_ovf = (op_a_q[MSB] != rhs[MSB]) && (sub_r[MSB] != op_a_q[MSB]);
            end
            OP_DISPLAY: alu_res = op_a_q;
            default:    alu_res = '0;
        endcase
    end

    // One multiplier bit per cycle; a zero bit still spends its cycle.
    always_comb begin
        partial = op_b_q[cnt_q] ? ({{DATA_W{1'b0}}, op_a_q} << cnt_q) : '0;
        acc_d   = acc_q + partial;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            prev_q        <= 1'b0;
            op_q          <= '0;
            src1_q        <= '0;
            src2_q        <= '0;
            dest_q        <= '0;
            imm_q         <= '0;
            op_a_q        <= '0;
            op_b_q        <= '0;
            result_q      <= '0;
            ovf_q         <= 1'b0;
            acc_q         <= '0;
            cnt_q         <= '0;
            valor_final_q <= '0;
            overflow_q    <= 1'b0;
            mostrar_q     <= 1'b0;
            done_q        <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
        end else begin
            sync1_q <= bus.enviar;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            done_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_q    <= bus.opcode;
                        src1_q  <= bus.src1;
                        src2_q  <= bus.src2;
                        dest_q  <= bus.dest;
                        imm_q   <= imm_ext;
                        state_q <= S_READ;
                    end
                end
                S_READ: begin
                    op_a_q  <= rf_q[src1_q];
                    op_b_q  <= rf_q[src2_q];
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    if (op_q == OP_MUL) begin
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= S_MULT;
                    end else begin
                        result_q <= alu_res;
                        ovf_q    <= alu_ovf;
                        state_q  <= S_WB;
                    end
                end
                S_MULT: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        result_q <= acc_d[DATA_W-1:0];
                        ovf_q    <= |acc_d[2*DATA_W-1:DATA_W];
                        state_q  <= S_WB;
                    end
                end
                S_WB: begin
                    if (op_q == OP_CLEAR) begin
                        for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
                    end else if (op_q != OP_DISPLAY) begin
                        rf_q[dest_q] <= result_q;
                    end
                    valor_final_q <= result_q;
                    overflow_q    <= ovf_q;
                    mostrar_q     <= (op_q != OP_CLEAR);
                    done_q        <= 1'b1;
                    state_q       <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = done_q;
    assign bus.valor_final = valor_final_q;
    assign bus.mostrar     = mostrar_q;
    assign bus.overflow    = overflow_q;
    assign bus.state_dbg   = state_q;
endmodule

// File: tb/tb_mini_cpu_param.sv
// Directed bench for mini_cpu_param: drivers push expected {overflow, mostrar, valor_final}
// and completion cycle; an independent monitor pops and compares on every done pulse.
module tb_mini_cpu_param;
  localparam int DATA_W = 16;
  localparam int REG_AW = 4;
  localparam int IMM_W  = 6;
  localparam int EXP_W  = DATA_W + 2;

  localparam logic [2:0] OP_LOAD = 3'd0, OP_ADD = 3'd1, OP_ADDI = 3'd2, OP_SUB = 3'd3;
  localparam logic [2:0] OP_SUBI = 3'd4, OP_MUL = 3'd5, OP_CLEAR = 3'd6, OP_DISPLAY = 3'd7;

  logic clk;
  logic rst_n;
  int   cyc;
  int   total;
  int   bad;
  int   done_cnt;
  int   issued;

  logic [EXP_W-1:0] exp_q[$];
  int               exp_cyc_q[$];

  mini_cpu_param_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .IMM_W(IMM_W)) bus ();

  mini_cpu_param #(.DATA_W(DATA_W), .REG_AW(REG_AW), .IMM_W(IMM_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 expected no completion (cycle %0d)", cyc);
      end else begin
        logic [EXP_W-1:0] e;
        int ec;
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check("result_ovf_mostrar_val", 32'({bus.overflow, bus.mostrar, bus.valor_final}), 32'(e));
        check("done_latency", 32'(cyc), 32'(ec));
        check("busy_low_with_done", 32'(bus.busy), 32'd0);
      end
    end
  end

  // drivers
  task automatic set_fields(input logic [2:0] op, input int s1, input int s2, input int d,
                            input logic sg, input int im);
    bus.opcode    = op;
    bus.src1      = REG_AW'(s1);
    bus.src2      = REG_AW'(s2);
    bus.dest      = REG_AW'(d);
    bus.sinal_imm = sg;
    bus.imm       = IMM_W'(im);
  endtask

  // Raise enviar and wait for acceptance; on accept push the expectation.
  task automatic press(input logic [2:0] op, input logic [DATA_W-1:0] ev, input logic eo,
                       input logic em, output logic ok);
    bus.enviar = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10 && !bus.busy; i++) @(negedge clk);
    if (!bus.busy) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got busy=0 expected busy=1 (cycle %0d)", cyc);
    end else begin
      ok = 1'b1;
      exp_q.push_back({eo, em, ev});
      exp_cyc_q.push_back(cyc + 3 + ((op == OP_MUL) ? DATA_W : 0));
      issued++;
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60 && bus.busy; i++) @(negedge clk);
    if (bus.busy) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got busy=1 expected busy=0 (cycle %0d)", cyc);
    end
  endtask

  task automatic issue(input logic [2:0] op, input int s1, input int s2, input int d,
                       input logic sg, input int im,
                       input logic [DATA_W-1:0] ev, input logic eo, input logic em);
    logic ok;
    set_fields(op, s1, s2, d, sg, im);
    press(op, ev, eo, em, ok);
    if (ok) wait_idle();
    bus.enviar = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int d0;
    logic ok;
    cyc = 0; total = 0; bad = 0; done_cnt = 0; issued = 0;
    rst_n = 1'b0;
    bus.enviar = 1'b0;
    set_fields(OP_LOAD, 0, 0, 0, 1'b0, 0);
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(bus.busy), 0);
    check("reset_done", 32'(bus.done), 0);
    check("reset_valor", 32'(bus.valor_final), 0);
    check("reset_flags", 32'({bus.mostrar, bus.overflow}), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_state", 32'(bus.state_dbg), 0);

    // 1: LOAD / DISPLAY, hold of outputs
    issue(OP_LOAD,    0, 0, 3, 1'b0, 5, 16'd5, 1'b0, 1'b1);
    issue(OP_DISPLAY, 3, 0, 0, 1'b0, 0, 16'd5, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    check("hold_valor", 32'(bus.valor_final), 32'd5);
    check("hold_mostrar", 32'(bus.mostrar), 32'd1);

    // 2: negative immediate, ADDI
    issue(OP_LOAD, 0, 0, 1, 1'b1, 3,  16'hFFFD, 1'b0, 1'b1);
    issue(OP_ADDI, 1, 0, 2, 1'b0, 10, 16'd7,    1'b0, 1'b1);

    // 3: multiplier and signed overflow corners
    issue(OP_LOAD, 0, 0, 1, 1'b0, 31, 16'd31,   1'b0, 1'b1);
    issue(OP_MUL,  1, 1, 2, 1'b0, 0,  16'd961,  1'b0, 1'b1);
    issue(OP_MUL,  2, 2, 3, 1'b0, 0,  16'd6017, 1'b1, 1'b1);
    issue(OP_LOAD, 0, 0, 6, 1'b0, 32, 16'd32,   1'b0, 1'b1);
    issue(OP_MUL,  6, 6, 7, 1'b0, 0,  16'd1024, 1'b0, 1'b1);
    issue(OP_MUL,  7, 6, 7, 1'b0, 0,  16'h8000, 1'b0, 1'b1);
    issue(OP_SUBI, 7, 0, 8, 1'b0, 1,  16'h7FFF, 1'b1, 1'b1);
    issue(OP_ADDI, 8, 0, 9, 1'b0, 1,  16'h8000, 1'b1, 1'b1);
    issue(OP_ADD,  8, 8, 10, 1'b0, 0, 16'hFFFE, 1'b1, 1'b1);
    issue(OP_SUB,  6, 7, 11, 1'b0, 0, 16'h8020, 1'b1, 1'b1);
    issue(OP_SUB,  3, 1, 12, 1'b0, 0, 16'd5986, 1'b0, 1'b1);
    issue(OP_SUBI, 1, 0, 13, 1'b1, 3, 16'd34,   1'b0, 1'b1);

    // 4: held button plus a second edge while busy -> a single execution
    issue(OP_LOAD, 0, 0, 5, 1'b0, 3, 16'd3, 1'b0, 1'b1);
    d0 = done_cnt;
    set_fields(OP_MUL, 5, 5, 5, 1'b0, 0);
    press(OP_MUL, 16'd9, 1'b0, 1'b1, ok);
    repeat (5) @(negedge clk);
    bus.enviar = 1'b0;
    repeat (3) @(negedge clk);
    bus.enviar = 1'b1;
    repeat (42) @(negedge clk);
    check("single_done_when_held", 32'(done_cnt - d0), 32'd1);
    bus.enviar = 1'b0;
    repeat (4) @(negedge clk);
    issue(OP_DISPLAY, 5, 0, 0, 1'b0, 0, 16'd9, 1'b0, 1'b1);

    // 5: CLEAR wipes the whole file
    for (int r = 0; r < 4; r++) issue(OP_LOAD, 0, 0, r, 1'b0, r + 1, 16'(r + 1), 1'b0, 1'b1);
    issue(OP_CLEAR, 0, 0, 0, 1'b0, 0, 16'd0, 1'b0, 1'b0);
    for (int r = 0; r < 4; r++) issue(OP_DISPLAY, r, 0, 0, 1'b0, 0, 16'd0, 1'b0, 1'b1);
    issue(OP_DISPLAY, 9, 0, 0, 1'b0, 0, 16'd0, 1'b0, 1'b1);

    // 6: reset in MULT cycle 5 aborts the instruction
    issue(OP_LOAD, 0, 0, 4, 1'b0, 7, 16'd7, 1'b0, 1'b1);
    set_fields(OP_MUL, 4, 4, 5, 1'b0, 0);
    bus.enviar = 1'b1;
    for (int i = 0; i < 20 && bus.state_dbg != 3'd3; i++) @(negedge clk);
    check("reached_mult", 32'(bus.state_dbg), 32'd3);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    bus.enviar = 1'b0;
    #1;
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_done", 32'(bus.done), 0);
    check("abort_valor", 32'(bus.valor_final), 0);
    check("abort_flags", 32'({bus.mostrar, bus.overflow}), 0);
    check("abort_state", 32'(bus.state_dbg), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    issue(OP_DISPLAY, 5, 0, 0, 1'b0, 0, 16'd0, 1'b0, 1'b1);
    issue(OP_DISPLAY, 4, 0, 0, 1'b0, 0, 16'd0, 1'b0, 1'b1);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("done_count", 32'(done_cnt), 32'(issued));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mini_cpu_param.md
Name: mini_cpu_param

Overview:
- Parametrised, multi-cycle successor to the team's 8-opcode mini CPU.
- Contains a NUM_REGS x DATA_W register file, a synchronised and edge-detected "enviar" issue button, a sequenced READ/EXEC/WB state machine, and an iterative shift-add multiplier.
- Adds overflow and completion reporting.
- Drives valor_final and the mostrar (LCD show/hide) flag for the display path.

Parameters:
- DATA_W, 16: register and result width (>= 8).
- REG_AW, 4: register address width; NUM_REGS = 2**REG_AW.
- IMM_W, 6: immediate magnitude width (< DATA_W).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enviar  in  1  raw issue button/level, asynchronous to clk.
- opcode  in  3  LOAD=000 ADD=001 ADDI=010 SUB=011 SUBI=100 MUL=101 CLEAR=110 DISPLAY=111.
- src1  in  REG_AW  operand A register index.
- src2  in  REG_AW  operand B register index.
- dest  in  REG_AW  destination register index.
- sinal_imm  in  1  immediate sign: 1 means negative.
- imm  in  IMM_W  immediate magnitude.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse on instruction completion.
- valor_final  out  DATA_W  last result.
- mostrar  out  1  LCD show flag.
- overflow  out  1  overflow of the last arithmetic instruction.

Behaviour:
- Reset, asynchronous on rst_n low:
  - All registers = 0; state = IDLE.
  - busy = 0, done = 0, valor_final = 0, mostrar = 0, overflow = 0.
  - Synchroniser flops = 0.
  - Reset mid-instruction aborts it: no register write, no done pulse.
- Issue:
  - enviar passes through a 2-flop synchroniser, then rising-edge detection produces start (one cycle per edge).
  - start is accepted only in IDLE. An edge arriving while busy is dropped, not queued.
  - Holding enviar high issues exactly once.
- On accept, latch opcode/src1/src2/dest. imm_ext = sinal_imm ? -zext(imm) : zext(imm), in DATA_W two's complement.
- States: IDLE -> READ -> EXEC -> WB -> IDLE; MUL takes EXEC -> MULT -> WB.
- READ: op_a = rf[src1], op_b = rf[src2].
- EXEC, computes result:
  - LOAD: imm_ext.
  - ADD: a+b. ADDI: a+imm_ext.
  - SUB: a-b. SUBI: a-imm_ext.
  - DISPLAY: op_a.
  - CLEAR: 0.
  - Widths: all results truncated to DATA_W.
  - ADD/ADDI/SUB/SUBI overflow: signed two's complement, i.e. operand signs agree (after negation for subtract) and result sign differs.
  - LOAD/DISPLAY/CLEAR overflow = 0.
- MULT:
  - Unsigned shift-add, exactly DATA_W cycles, counter 0..DATA_W-1, 2*DATA_W-bit accumulator.
  - result = low DATA_W bits; overflow = |high DATA_W bits.
  - A multiplier bit of 0 still consumes its cycle (fixed latency).
- WB:
  - Write rf[dest] = result for LOAD/ADD/ADDI/SUB/SUBI/MUL.
  - CLEAR zeroes all NUM_REGS registers in this single cycle.
  - DISPLAY writes nothing.
  - On the edge leaving WB: valor_final = result, overflow updated, done = 1 for one cycle.
  - mostrar = 0 for CLEAR, 1 for all other opcodes.
- Latency:
  - Accept cycle T is IDLE with start = 1; then READ at T+1, EXEC at T+2, WB at T+3.
  - Outputs and done visible at T+4 for non-MUL; T+4+DATA_W for MUL.
  - enviar edge to start adds 2-3 cycles.
- Hazards: src = dest of the previous instruction always sees the written value, because instructions are serialised.
- busy deasserts the same cycle done asserts.
- valor_final, overflow and mostrar hold until the next completion.

Test Plan:
1. LOAD sinal=0 imm=5 dest=r3, then DISPLAY src1=r3 -> valor_final=5, mostrar=1, overflow=0, done pulses once each, done at T+4.
2. LOAD r1 with sinal=1 imm=3 -> 0xFFFD; ADDI src1=r1, dest=r2, imm=10 -> valor_final=7, overflow=0.
3. LOAD r1=31; MUL r1*r1 -> r2=961, overflow=0, done at T+20; MUL r2*r2 -> r3=6017 (923521 mod 65536), overflow=1.
4. Hold enviar high for 50 cycles, plus a second edge while busy -> exactly one done, one register write.
5. Load r0..r3 with nonzero values; CLEAR -> mostrar=0, valor_final=0; DISPLAY of each -> 0.
6. Assert rst_n low during MULT cycle 5 -> busy=0, all outputs 0; DISPLAY of dest after release reads 0; no done pulse at abort.
